// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED PWM controller: register word indices, LED mode
// encodings, counter widths and the bus response state type.
package led_ctrl_pkg;

   localparam int PRESC_W = 8;
   localparam int PWM_W   = 8;
   localparam int BLINK_W = 16;
   localparam int MODE_W  = 16;
   localparam int DUTY_W  = 64;

   // Word index = byte offset [7:2]
   localparam logic [5:0] REG_CTRL  = 6'h00;
   localparam logic [5:0] REG_MODE  = 6'h01;
   localparam logic [5:0] REG_DUTYA = 6'h02;
   localparam logic [5:0] REG_DUTYB = 6'h03;
   localparam logic [5:0] REG_BLINK = 6'h04;
   localparam logic [5:0] REG_STAT  = 6'h05;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } led_mode_e;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_RESP = 1'b1
   } bus_state_e;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// picorv32 native memory bus as seen by the LED controller.
interface led_pwm_ctrl_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: selects off/on/blink/pwm and registers the pin drive.
module led_pwm_channel
   import led_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  led_mode_e        mode,
   input  logic [PWM_W-1:0] duty,
   input  logic [PWM_W-1:0] pwm_cnt,
   input  logic             phase,
   output logic             led
);

   logic led_d;

   always_comb begin
      led_d = 1'b0;
      case (mode)
         MODE_OFF:   led_d = 1'b0;
         MODE_ON:    led_d = 1'b1;
         MODE_BLINK: led_d = phase;
         MODE_PWM:   led_d = (pwm_cnt < duty);
         default:    led_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led <= 1'b0;
      end else begin
         led <= en & led_d;
      end
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped 8-channel LED controller: bus slave, config registers, duty
// shadowing, prescaler/PWM/blink timebase and per-channel output stages.
//
// state    | meaning
// BUS_IDLE | waiting for a selected request
// BUS_RESP | mem_ready high this cycle; write data commits at the end of it
module led_pwm_ctrl
   import led_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int          NUM_LEDS  = 8
)(
   input  logic                clk,
   input  logic                reset,
   led_pwm_ctrl_if.slave       bus,
   output logic [NUM_LEDS-1:0] led
);

   bus_state_e state_q, state_d;

   logic               hit;
   logic               sel;
   logic               wr_en;
   logic [5:0]         req_idx;
   logic [31:0]        req_wdata;
   logic [3:0]         req_wstrb;
   logic [31:0]        rd_val;
   logic [31:0]        rdata_q;
   logic               unused_addr_bits;

   logic               en_q;
   logic [PRESC_W-1:0] presc_q;
   logic [MODE_W-1:0]  mode_q;
   logic [DUTY_W-1:0]  duty_stage_q;
   logic [DUTY_W-1:0]  duty_act_q;
   logic [BLINK_W-1:0] blink_q;

   logic [PRESC_W-1:0] pre_cnt_q;
   logic [PWM_W-1:0]   pwm_cnt_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               phase_q;
   logic               tick;
   logic               frame_end;

   assign unused_addr_bits = ^bus.mem_addr[1:0];

   assign hit   = (bus.mem_addr[31:8] == BASE_ADDR[31:8]);
   assign sel   = bus.mem_valid && hit && (state_q == BUS_IDLE);
   assign wr_en = (state_q == BUS_RESP) && (req_wstrb != 4'b0000);

   assign bus.mem_ready = (state_q == BUS_RESP);
   assign bus.mem_rdata = rdata_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         BUS_IDLE: if (sel) state_d = BUS_RESP;
         BUS_RESP: state_d = BUS_IDLE;
         default:  state_d = BUS_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      case (bus.mem_addr[7:2])
         REG_CTRL:  rd_val = {16'h0, presc_q, 7'h0, en_q};
         REG_MODE:  rd_val = {16'h0, mode_q};
         REG_DUTYA: rd_val = duty_stage_q[31:0];
         REG_DUTYB: rd_val = duty_stage_q[63:32];
         REG_BLINK: rd_val = {16'h0, blink_q};
         REG_STAT:  rd_val = {16'h0, pwm_cnt_q, led};
         default:   rd_val = '0;
      endcase
   end

   // Request is captured on select and committed during the response cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BUS_IDLE;
         rdata_q   <= '0;
         req_idx   <= '0;
         req_wdata <= '0;
         req_wstrb <= '0;
      end else begin
         state_q <= state_d;
         if (sel) begin
            rdata_q   <= rd_val;
            req_idx   <= bus.mem_addr[7:2];
            req_wdata <= bus.mem_wdata;
            req_wstrb <= bus.mem_wstrb;
         end else begin
            rdata_q   <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q         <= 1'b0;
         presc_q      <= '0;
         mode_q       <= '0;
         duty_stage_q <= '0;
         blink_q      <= '0;
      end else if (wr_en) begin
         case (req_idx)
            REG_CTRL: begin
               if (req_wstrb[0]) en_q    <= req_wdata[0];
               if (req_wstrb[1]) presc_q <= req_wdata[15:8];
            end
            REG_MODE: begin
               if (req_wstrb[0]) mode_q[7:0]  <= req_wdata[7:0];
               if (req_wstrb[1]) mode_q[15:8] <= req_wdata[15:8];
            end
            REG_DUTYA: begin
               for (int b = 0; b < 4; b++)
                  if (req_wstrb[b]) duty_stage_q[8*b +: 8] <= req_wdata[8*b +: 8];
            end
            REG_DUTYB: begin
               for (int b = 0; b < 4; b++)
                  if (req_wstrb[b]) duty_stage_q[32+8*b +: 8] <= req_wdata[8*b +: 8];
            end
            REG_BLINK: begin
               if (req_wstrb[0]) blink_q[7:0]  <= req_wdata[7:0];
               if (req_wstrb[1]) blink_q[15:8] <= req_wdata[15:8];
            end
            default: ;
         endcase
      end
   end

   assign tick      = en_q && (pre_cnt_q == presc_q);
   assign frame_end = tick && (pwm_cnt_q == 8'hFF);

   always_ff @(posedge clk) begin
      if (reset || !en_q) begin
         pre_cnt_q   <= '0;
         pwm_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         pre_cnt_q <= tick ? '0 : pre_cnt_q + 8'd1;
         if (tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;
         if (frame_end) begin
            if (blink_cnt_q == blink_q) begin
               blink_cnt_q <= '0;
               phase_q     <= ~phase_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 16'd1;
            end
         end
      end
   end

   // Active duty only changes at a frame boundary so a pulse is never cut short.
   always_ff @(posedge clk) begin
      if (reset) begin
         duty_act_q <= '0;
      end else if (!en_q || frame_end) begin
         duty_act_q <= duty_stage_q;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_pwm_channel u_ch (
         .clk     (clk),
         .reset   (reset),
         .en      (en_q),
         .mode    (led_mode_e'(mode_q[2*i +: 2])),
         .duty    (duty_act_q[8*i +: 8]),
         .pwm_cnt (pwm_cnt_q),
         .phase   (phase_q),
         .led     (led[i])
      );
   end

endmodule
